// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton debounce reader: channel FSM encoding
// and default timing constants.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_DN = 2'd1,
    DOWN   = 2'd2,
    ARM_UP = 2'd3
  } btn_state_t;

  localparam int DEF_N_BTN      = 4;
  localparam int DEF_TICK_DIV   = 19;
  localparam int DEF_DEB_TICKS  = 4;
  localparam int DEF_LONG_TICKS = 64;

endpackage

// File: rtl/button_channel.sv
// One debounced button channel: IDLE/ARM_DN/DOWN/ARM_UP FSM with a debounce
// counter (ticks of stable level) and a hold counter (ticks spent pressed).
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_s,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = $clog2(DEB_TICKS);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_TICKS);

  btn_state_t    r_state, w_state_nx;
  logic [DW-1:0] r_dcnt, w_dcnt_nx;
  logic [HW-1:0] r_hcnt, w_hcnt_nx;
  logic          w_level_nx, w_press_nx, w_release_nx, w_long_nx;

  // Next-state and registered-output decode; a level mismatch always wins over a tick.
  always_comb begin
    w_state_nx   = r_state;
    w_dcnt_nx    = r_dcnt;
    w_hcnt_nx    = r_hcnt;
    w_level_nx   = o_level;
    w_press_nx   = 1'b0;
    w_release_nx = 1'b0;
    w_long_nx    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_s) begin
          w_state_nx = ARM_DN;
          w_dcnt_nx  = '0;
        end
      end
      ARM_DN: begin
        if (!i_s) begin
          w_state_nx = IDLE;
        end else if (i_tick) begin
          if (r_dcnt == DCNT_LAST) begin
            w_state_nx = DOWN;
            w_level_nx = 1'b1;
            w_press_nx = 1'b1;
            w_hcnt_nx  = '0;
          end else begin
            w_dcnt_nx = r_dcnt + DW'(1);
          end
        end
      end
      DOWN: begin
        if (!i_s) begin
          w_state_nx = ARM_UP;
          w_dcnt_nx  = '0;
        end else if (i_tick && (r_hcnt != HCNT_MAX)) begin
          // Saturation makes the LONG_TICKS crossing happen once per hold.
          w_hcnt_nx = r_hcnt + HW'(1);
          w_long_nx = (r_hcnt == HCNT_MAX - HW'(1));
        end
      end
      ARM_UP: begin
        // Bounce back to pressed keeps hcnt so a glitch cannot re-arm oLONG.
        if (i_s) begin
          w_state_nx = DOWN;
        end else if (i_tick) begin
          if (r_dcnt == DCNT_LAST) begin
            w_state_nx   = IDLE;
            w_level_nx   = 1'b0;
            w_release_nx = 1'b1;
          end else begin
            w_dcnt_nx = r_dcnt + DW'(1);
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State, counters and event outputs; reset clears pulses in the reset cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_dcnt    <= w_dcnt_nx;
      r_hcnt    <= w_hcnt_nx;
      o_level   <= w_level_nx;
      o_press   <= w_press_nx;
      o_release <= w_release_nx;
      o_long    <= w_long_nx;
    end
  end

endmodule

// File: rtl/button_debounce_reader.sv
// N-button reader: 2-FF synchroniser per pin, one shared sample prescaler,
// and an array of independent debounce channels.
module button_debounce_reader
  import button_pkg::*;
#(
  parameter int N_BTN      = DEF_N_BTN,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [N_BTN-1:0] iBTN,
  output logic [N_BTN-1:0] oLEVEL,
  output logic [N_BTN-1:0] oPRESS,
  output logic [N_BTN-1:0] oRELEASE,
  output logic [N_BTN-1:0] oLONG,
  output logic             oTICK
);

  logic [N_BTN-1:0]    r_sync1, r_sync2;
  logic [TICK_DIV-1:0] r_pre;
  logic                w_tick;

  // Tick on the all-ones count; the counter then wraps to zero on its own.
  assign w_tick = &r_pre;
  assign oTICK  = w_tick;

  // Pin synchroniser and free-running prescaler.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_pre   <= '0;
    end else begin
      r_sync1 <= iBTN;
      r_sync2 <= r_sync1;
      r_pre   <= r_pre + TICK_DIV'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .DEB_TICKS (DEB_TICKS),
      .LONG_TICKS(LONG_TICKS)
    ) u_ch (
      .i_clk    (iCLK),
      .i_rst    (iRST),
      .i_s      (r_sync2[g]),
      .i_tick   (w_tick),
      .o_level  (oLEVEL[g]),
      .o_press  (oPRESS[g]),
      .o_release(oRELEASE[g]),
      .o_long   (oLONG[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_reader.sv
// Directed scenarios plus random pin activity, checked every cycle against a
// run-length model of the debounce rules.
module tb_button_debounce_reader;

  localparam int N = 4, TD = 3, P = 8, DEB = 4, LONG = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] level, press, rel, lng;
  logic         tick;

  button_debounce_reader #(
    .N_BTN(N), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG)
  ) dut (
    .iCLK(clk), .iRST(rst), .iBTN(btn),
    .oLEVEL(level), .oPRESS(press), .oRELEASE(rel), .oLONG(lng), .oTICK(tick)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;

  // Reference model: synchronised pins, phase in sample period, accepted level,
  // whether a mismatch run is in progress, ticks seen in that run, ticks held.
  logic [N-1:0] m_s1, m_s, m_lvl, e_press, e_rel, e_long;
  logic         e_tick;
  int           pc;
  bit           inrun [N];
  int           k [N], hold [N];

  int c_press [N], c_rel [N], c_long [N];
  int press_at [N], long_at [N];
  bit saw_all;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit t, s, ino;
    if (rst) begin
      m_s1 = '0; m_s = '0; m_lvl = '0; pc = 0;
      e_press = '0; e_rel = '0; e_long = '0; e_tick = 1'b0;
      for (int b = 0; b < N; b++) begin inrun[b] = 0; k[b] = 0; hold[b] = 0; end
    end else begin
      t  = (pc == P - 1);
      pc = (pc + 1) % P;
      e_tick = (pc == P - 1);
      e_press = '0; e_rel = '0; e_long = '0;
      for (int b = 0; b < N; b++) begin
        s   = m_s[b];
        ino = inrun[b];
        // Held and settled: count sample ticks toward a long press.
        if (m_lvl[b] && s && !ino && t && hold[b] < LONG) begin
          hold[b]++;
          if (hold[b] == LONG) e_long[b] = 1'b1;
        end
        if (s == m_lvl[b]) begin
          inrun[b] = 0; k[b] = 0;
        end else if (!ino) begin
          inrun[b] = 1; k[b] = 0;
        end else if (t) begin
          k[b]++;
          if (k[b] == DEB) begin
            m_lvl[b] = ~m_lvl[b];
            if (m_lvl[b]) begin e_press[b] = 1'b1; hold[b] = 0; end
            else e_rel[b] = 1'b1;
            inrun[b] = 0; k[b] = 0;
          end
        end
      end
      m_s  = m_s1;
      m_s1 = btn;
    end
  endtask

  task automatic step(input logic [N-1:0] b);
    btn = b;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("level", level, m_lvl);
    chk("press", press, e_press);
    chk("release", rel, e_rel);
    chk("long", lng, e_long);
    chk("tick", tick, e_tick);
    if (press == '1) saw_all = 1;
    for (int i = 0; i < N; i++) begin
      if (press[i]) begin c_press[i]++; press_at[i] = cyc; end
      if (rel[i])   c_rel[i]++;
      if (lng[i])   begin c_long[i]++; long_at[i] = cyc; end
    end
  endtask

  task automatic hold_btn(input logic [N-1:0] b, input int n);
    repeat (n) step(b);
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      c_press[i] = 0; c_rel[i] = 0; c_long[i] = 0; press_at[i] = 0; long_at[i] = 0;
    end
    saw_all = 0;
  endtask

  initial begin
    int start, d;
    rst = 1'b1;
    btn = '0;
    clr();
    hold_btn(4'b0000, 3);
    chk("reset_level", level, 0);
    rst = 1'b0;

    // 1: clean press on bit 0
    clr(); start = cyc;
    hold_btn(4'b0001, 100);
    d = press_at[0] - start;
    chk("s1_press_cnt", c_press[0], 1);
    chk("s1_press_win", (d >= 24 && d <= 35), 1);
    chk("s1_other_press", c_press[1] + c_press[2] + c_press[3], 0);
    chk("s1_level", level, 4'b0001);
    hold_btn(4'b0000, 60);
    chk("s1_release_cnt", c_rel[0], 1);

    // 2: bounce on bit 1
    clr();
    for (int i = 0; i < 12; i++) hold_btn((i % 2) ? 4'b0000 : 4'b0010, 5);
    hold_btn(4'b0000, 40);
    chk("s2_events", c_press[1] + c_rel[1] + c_long[1], 0);
    chk("s2_level", level[1], 0);

    // 3: long press on bit 2
    clr();
    hold_btn(4'b0100, 200);
    hold_btn(4'b0000, 60);
    chk("s3_press_cnt", c_press[2], 1);
    chk("s3_long_cnt", c_long[2], 1);
    chk("s3_long_delay", long_at[2] - press_at[2], 64);
    chk("s3_release_cnt", c_rel[2], 1);
    chk("s3_level", level[2], 0);

    // 4: release glitch while bit 0 is down
    clr();
    hold_btn(4'b0001, 60);
    hold_btn(4'b0000, 6);
    hold_btn(4'b0001, 40);
    chk("s4_press_cnt", c_press[0], 1);
    chk("s4_no_release", c_rel[0], 0);
    chk("s4_level", level[0], 1);
    hold_btn(4'b0000, 60);

    // 5: all four pressed in the same cycle
    clr();
    hold_btn(4'b1111, 50);
    chk("s5_same_cycle", saw_all, 1);
    hold_btn(4'b0000, 60);

    // 6: reset while bit 3 is mid-debounce
    clr();
    hold_btn(4'b1000, 15);
    chk("s6_pre_press", c_press[3], 0);
    rst = 1'b1;
    hold_btn(4'b1000, 2);
    chk("s6_rst_out", {level, press, rel, lng}, 0);
    rst = 1'b0;
    clr(); start = cyc;
    hold_btn(4'b1000, 50);
    d = press_at[3] - start;
    chk("s6_press_cnt", c_press[3], 1);
    chk("s6_press_win", (d >= 24 && d <= 35), 1);
    hold_btn(4'b0000, 60);

    // random pin activity
    for (int i = 0; i < 60; i++)
      hold_btn(N'($urandom), int'($urandom_range(1, 45)));
    hold_btn(4'b0000, 60);
    chk("rand_idle_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
